bin2bcd_seq: RTL and testbench

Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter. Sits directly upstream of the seven-segment scan/multiplex stage and turns the binary display counter value into per-digit BCD nibbles. The display stage then only has to select and decode nibbles, with no divide or modulo logic. Valid/ready on both sides; one conversion in flight.

---
 rtl/bin2bcd_seq.sv | 132 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready on both sides.
// Optional LEADING_ZERO_BLANK_EN: digits above the most significant nonzero digit are output as 4'hF.
module bin2bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  localparam longint unsigned BCD_MAX = 64'(10) ** DIGITS - 64'd1;
  localparam longint unsigned BIN_MAX = (64'd1 << BIN_W) - 64'd1;

  if (BCD_MAX < BIN_MAX) begin : g_range_err
    $error("bin2bcd_seq: DIGITS too small to hold 2^BIN_W-1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WORK_W-1:0]   work, work_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [BCD_W-1:0]    out_bcd_nxt;
  logic [BCD_W-1:0]    bcd_corr;
  logic [WORK_W-1:0]   work_shift;
  logic                last;
  logic                load;

  // Per-nibble +3 when >= 5; 4-bit adders, no carry between digits.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) r[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit 0 is never blanked so that zero still shows a single 0.
  function automatic logic [BCD_W-1:0] finalize(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    logic             seen;
    r    = bcd;
    seen = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (bcd[4*k +: 4] != 4'd0) seen = 1'b1;
      if (!seen) r[4*k +: 4] = 4'hF;
    end
    return r;
  endfunction
`else
  function automatic logic [BCD_W-1:0] finalize(input logic [BCD_W-1:0] bcd);
    return bcd;
  endfunction
`endif

  assign bcd_corr   = add3_digits(work[WORK_W-1 -: BCD_W]);
  assign work_shift = {bcd_corr, work[BIN_W-1:0]} << 1;
  assign last       = (cnt == CNT_W'(1));

  always_comb begin
    state_nxt   = state;
    work_nxt    = work;
    cnt_nxt     = cnt;
    out_bcd_nxt = out_bcd;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      SHIFT: begin
        busy     = 1'b1;
        work_nxt = work_shift;
        cnt_nxt  = cnt - CNT_W'(1);
        if (last) begin
          out_bcd_nxt = finalize(work_shift[WORK_W-1 -: BCD_W]);
          state_nxt   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          load = in_valid;
          if (!in_valid) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      work_nxt  = {{BCD_W{1'b0}}, in_bin};
      cnt_nxt   = CNT_W'(BIN_W);
      state_nxt = SHIFT;
    end
  end

  // Register stage: FSM, working register, bit counter and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      out_bcd <= '0;
    end else begin
      state   <= state_nxt;
      work    <= work_nxt;
      cnt     <= cnt_nxt;
      out_bcd <= out_bcd_nxt;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized + directed bench for bin2bcd_seq against an arithmetic (divide/modulo) reference.
// Honours LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 12;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [BCD_W-1:0] E0 = 16'hFFF0, E999 = 16'hF999, E7 = 16'hFFF7, E456 = 16'hF456;
`else
  localparam logic [BCD_W-1:0] E0 = 16'h0000, E999 = 16'h0999, E7 = 16'h0007, E456 = 16'h0456;
`endif
  localparam logic [BCD_W-1:0] E4095 = 16'h4095, E1000 = 16'h1000, E2048 = 16'h2048;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BIN_W-1:0]  in_bin = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [BCD_W-1:0]  out_bcd;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Decimal digits by division, then optional blanking of leading zero digits.
  function automatic logic [BCD_W-1:0] ref_bcd(input logic [BIN_W-1:0] v);
    logic [BCD_W-1:0] r;
    int unsigned      x;
    int               top;
    x   = v;
    top = 0;
    r   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      if (x % 10 != 0) top = k;
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = top + 1; k < DIGITS; k++) r[4*k +: 4] = 4'hF;
`endif
    return r;
  endfunction

  // Monitor / scoreboard, sampling 2 time units after each falling edge.
  int               cyc = 0;
  logic [BCD_W-1:0] exp_q[$];
  int               acc_q[$];
  int               rise_q[$];
  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic [BCD_W-1:0] last_res = '0;
  int               busy_run = 0;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      busy_run   = 0;
      last_res   = '0;
    end else begin
      if (busy) begin
        busy_run++;
        check("in_ready_in_shift", 64'(in_ready), 64'd0);
      end else if (busy_run != 0) begin
        check("busy_len", 64'(busy_run), 64'(BIN_W));
        busy_run = 0;
      end
      if (out_valid) check("in_ready_in_done", 64'(in_ready), 64'(out_ready));
      else check("out_bcd_held", 64'(out_bcd), 64'(last_res));
      if (out_valid && !prev_valid) begin
        rise_q.push_back(cyc);
        check("inflight_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
          check("latency", 64'(cyc - acc_q[0]), 64'(BIN_W + 1));
          check("bcd", 64'(out_bcd), 64'(exp_q[0]));
          last_res = exp_q[0];
        end
      end else if (out_valid && !prev_ready && exp_q.size() != 0) begin
        check("bcd_stall_hold", 64'(out_bcd), 64'(exp_q[0]));
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_bcd(in_bin));
        acc_q.push_back(cyc);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
  end

  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic send(input logic [BIN_W-1:0] v, output int waited);
    in_valid = 1'b1;
    in_bin   = v;
    waited   = 0;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_bin   = BIN_W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || busy) && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic convert_and_check(input logic [BIN_W-1:0] v, input logic [BCD_W-1:0] e, input string tag);
    int w;
    send(v, w);
    idle_in();
    drain();
    check(tag, 64'(out_bcd), 64'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int               w, n, rb;
    logic [BIN_W-1:0] v, pend;

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_bcd", 64'(out_bcd), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;

    convert_and_check(12'd0,    E0,    "val_0");
    convert_and_check(12'd4095, E4095, "val_4095");
    convert_and_check(12'd999,  E999,  "val_999");
    convert_and_check(12'd1000, E1000, "val_1000");
    convert_and_check(12'd7,    E7,    "val_7");

    // Back-to-back with in_valid held and out_ready high.
    rb = rise_q.size();
    send(12'd123, w);
    send(12'd456, w);
    idle_in();
    drain();
    check("b2b_count", 64'(rise_q.size() - rb), 64'd2);
    if (rise_q.size() - rb >= 2)
      check("b2b_spacing", 64'(rise_q[rb+1] - rise_q[rb]), 64'(BIN_W + 1));
    check("b2b_last", 64'(out_bcd), 64'(E456));

    // Backpressure: hold result 20 cycles with a pending input waiting.
    pend = BIN_W'($urandom_range(1, 4095));
    out_ready = 1'b0;
    send(BIN_W'($urandom), w);
    idle_in();
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    in_bin   = pend;
    repeat (20) @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(pend, w);
    check("bp_first_accept", 64'(w), 64'd0);
    idle_in();
    drain();
    check("bp_result", 64'(out_bcd), 64'(ref_bcd(pend)));

    // Reset in the middle of a conversion.
    send(12'd2048, w);
    idle_in();
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_bcd", 64'(out_bcd), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #4 rst_n = 1'b1;
    @(negedge clk);
    convert_and_check(12'd2048, E2048, "val_2048_after_rst");

    // Random values with random stalls and gaps.
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0)      v = 12'd4095;
      else if (i % 8 == 1) v = 12'd0;
      else                 v = BIN_W'($urandom);
      out_ready = 1'b1;
      send(v, w);
      if ($urandom_range(0, 1) == 1) idle_in();
      out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 16)) @(negedge clk);
      out_ready = 1'b1;
    end
    idle_in();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
